// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with a two-entry skid buffer.
// MAIN drives the execute side; SKID absorbs one instruction when execute stalls.
module id_ex_stage #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned REG_NUM    = 32,
    parameter int unsigned OP_WIDTH   = 8,
    localparam int unsigned RW        = $clog2(REG_NUM)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,

    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_rs1_val,
    input  logic [DATA_WIDTH-1:0] in_rs2_val,
    input  logic [RW-1:0]         in_rs1,
    input  logic [RW-1:0]         in_rs2,
    input  logic [RW-1:0]         in_rd,
    input  logic                  in_rd_we,
    input  logic [DATA_WIDTH-1:0] in_pc,
    input  logic [OP_WIDTH-1:0]   in_op,

    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_rs1_val,
    output logic [DATA_WIDTH-1:0] out_rs2_val,
    output logic [RW-1:0]         out_rs1,
    output logic [RW-1:0]         out_rs2,
    output logic [RW-1:0]         out_rd,
    output logic                  out_rd_we,
    output logic [DATA_WIDTH-1:0] out_pc,
    output logic [OP_WIDTH-1:0]   out_op,

    output logic [RW-1:0]         ex_rd,
    output logic                  ex_rd_we
);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] rs1_val;
        logic [DATA_WIDTH-1:0] rs2_val;
        logic [RW-1:0]         rs1;
        logic [RW-1:0]         rs2;
        logic [RW-1:0]         rd;
        logic                  rd_we;
        logic [DATA_WIDTH-1:0] pc;
        logic [OP_WIDTH-1:0]   op;
    } payload_t;

    payload_t r_main;
    payload_t r_skid;
    logic     r_main_valid;
    logic     r_skid_valid;

    payload_t w_in_payload;
    logic     w_accept;
    logic     w_consume;
    logic     w_main_valid_nxt;
    logic     w_skid_valid_nxt;
    logic     w_main_from_in;
    logic     w_main_from_skid;
    logic     w_skid_from_in;

    // Ready depends on registered state only, so no combinational path from out_ready.
    assign in_ready  = !r_skid_valid;
    assign out_valid = r_main_valid;
    assign w_accept  = in_valid && in_ready;
    assign w_consume = r_main_valid && out_ready;

    // x0 writes are masked at capture time so downstream never sees a live rd_we for rd 0.
    always_comb begin
        w_in_payload         = '0;
        w_in_payload.rs1_val = in_rs1_val;
        w_in_payload.rs2_val = in_rs2_val;
        w_in_payload.rs1     = in_rs1;
        w_in_payload.rs2     = in_rs2;
        w_in_payload.rd      = in_rd;
        w_in_payload.rd_we   = in_rd_we && (in_rd != '0);
        w_in_payload.pc      = in_pc;
        w_in_payload.op      = in_op;
    end

    always_comb begin
        w_main_valid_nxt = r_main_valid;
        w_skid_valid_nxt = r_skid_valid;
        w_main_from_in   = 1'b0;
        w_main_from_skid = 1'b0;
        w_skid_from_in   = 1'b0;

        if (flush) begin
            w_main_valid_nxt = 1'b0;
            w_skid_valid_nxt = 1'b0;
        end else if (w_consume && r_skid_valid) begin
            // in_ready is low here, so no accept can coincide with the refill.
            w_main_from_skid = 1'b1;
            w_main_valid_nxt = 1'b1;
            w_skid_valid_nxt = 1'b0;
        end else if (w_accept && (!r_main_valid || w_consume)) begin
            w_main_from_in   = 1'b1;
            w_main_valid_nxt = 1'b1;
        end else if (w_accept) begin
            w_skid_from_in   = 1'b1;
            w_skid_valid_nxt = 1'b1;
        end else if (w_consume) begin
            w_main_valid_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
            r_main       <= '0;
            r_skid       <= '0;
        end else begin
            r_main_valid <= w_main_valid_nxt;
            r_skid_valid <= w_skid_valid_nxt;
            if (w_main_from_skid) begin
                r_main <= r_skid;
            end else if (w_main_from_in) begin
                r_main <= w_in_payload;
            end
            if (w_skid_from_in) begin
                r_skid <= w_in_payload;
            end
        end
    end

    assign out_rs1_val = r_main.rs1_val;
    assign out_rs2_val = r_main.rs2_val;
    assign out_rs1     = r_main.rs1;
    assign out_rs2     = r_main.rs2;
    assign out_rd      = r_main.rd;
    assign out_rd_we   = r_main.rd_we;
    assign out_pc      = r_main.pc;
    assign out_op      = r_main.op;

    assign ex_rd       = r_main.rd;
    assign ex_rd_we    = r_main.rd_we && r_main_valid;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed and randomized checks for id_ex_stage: stream, backpressure, flush, rd0, reset.
module tb_id_ex_stage;

    localparam int DW = 64;
    localparam int RN = 32;
    localparam int OW = 8;
    localparam int RW = 5;

    logic          clk = 1'b0;
    logic          rst_n, flush, in_valid, in_ready, in_rd_we;
    logic [DW-1:0] in_rs1_val, in_rs2_val, in_pc;
    logic [RW-1:0] in_rs1, in_rs2, in_rd;
    logic [OW-1:0] in_op;
    logic          out_valid, out_ready, out_rd_we, ex_rd_we;
    logic [DW-1:0] out_rs1_val, out_rs2_val, out_pc;
    logic [RW-1:0] out_rs1, out_rs2, out_rd, ex_rd;
    logic [OW-1:0] out_op;

    int n_asserts = 0;
    int n_fail    = 0;

    id_ex_stage #(.DATA_WIDTH(DW), .REG_NUM(RN), .OP_WIDTH(OW)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_rd_we(in_rd_we),
        .in_pc(in_pc), .in_op(in_op),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_rs1_val(out_rs1_val), .out_rs2_val(out_rs2_val),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd), .out_rd_we(out_rd_we),
        .out_pc(out_pc), .out_op(out_op),
        .ex_rd(ex_rd), .ex_rd_we(ex_rd_we)
    );

    always #5 clk = ~clk;

    // Operand fields are a fixed function of pc so any payload can be predicted from its pc.
    function automatic logic [DW-1:0] f_rs1_val(input logic [DW-1:0] pc);
        return {pc[31:0], ~pc[31:0]};
    endfunction
    function automatic logic [DW-1:0] f_rs2_val(input logic [DW-1:0] pc);
        return pc * 3 + 64'h1234;
    endfunction
    function automatic logic [RW-1:0] f_rs1(input logic [DW-1:0] pc);
        return pc[6:2];
    endfunction
    function automatic logic [RW-1:0] f_rs2(input logic [DW-1:0] pc);
        return pc[4:0] ^ 5'h1f;
    endfunction
    function automatic logic [OW-1:0] f_op(input logic [DW-1:0] pc);
        return pc[9:2];
    endfunction

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_payload(input string tag, input logic [DW-1:0] pc);
        check({tag, ".pc"}, out_pc, pc);
        check({tag, ".rs1_val"}, out_rs1_val, f_rs1_val(pc));
        check({tag, ".rs2_val"}, out_rs2_val, f_rs2_val(pc));
        check({tag, ".rs1"}, DW'(out_rs1), DW'(f_rs1(pc)));
        check({tag, ".rs2"}, DW'(out_rs2), DW'(f_rs2(pc)));
        check({tag, ".op"}, DW'(out_op), DW'(f_op(pc)));
    endtask

    task automatic drive(input logic v, input logic [DW-1:0] pc, input logic [RW-1:0] rd,
                         input logic we);
        in_valid   = v;
        in_pc      = pc;
        in_rs1_val = f_rs1_val(pc);
        in_rs2_val = f_rs2_val(pc);
        in_rs1     = f_rs1(pc);
        in_rs2     = f_rs2(pc);
        in_op      = f_op(pc);
        in_rd      = rd;
        in_rd_we   = we;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [DW-1:0] q[$];
    logic [DW-1:0] next_pc, exp_pc, held_pc;
    logic          held, acc, con;
    int            drain;

    initial begin
        rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
        drive(1'b0, '0, '0, 1'b0);
        step(); step();
        rst_n = 1'b1;

        // Reset state
        check("rst.out_valid", DW'(out_valid), 0);
        check("rst.in_ready", DW'(in_ready), 1);
        check("rst.out_rd_we", DW'(out_rd_we), 0);
        check("rst.ex_rd", DW'(ex_rd), 0);
        check("rst.ex_rd_we", DW'(ex_rd_we), 0);
        check("rst.out_pc", out_pc, 0);
        check("rst.out_rs1_val", out_rs1_val, 0);

        // Stream at full rate
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 64'h100 + 64'(4 * i), 5'd1, 1'b1);
            check("stream.in_ready", DW'(in_ready), 1);
            step();
            check("stream.out_valid", DW'(out_valid), 1);
            check_payload("stream", 64'h100 + 64'(4 * i));
        end
        drive(1'b0, '0, '0, 1'b0);
        step();
        check("stream.drained", DW'(out_valid), 0);

        // Backpressure fills both entries
        out_ready = 1'b0;
        drive(1'b1, 64'h200, 5'd2, 1'b1);
        step();
        check("bp.in_ready1", DW'(in_ready), 1);
        check("bp.pc1", out_pc, 64'h200);
        drive(1'b1, 64'h204, 5'd3, 1'b1);
        step();
        check("bp.in_ready2", DW'(in_ready), 0);
        check("bp.pc2", out_pc, 64'h200);
        drive(1'b0, '0, '0, 1'b0);
        step();
        check("bp.hold", out_pc, 64'h200);
        check("bp.hold_valid", DW'(out_valid), 1);
        out_ready = 1'b1;
        step();
        check_payload("bp.second", 64'h204);
        check("bp.in_ready3", DW'(in_ready), 1);
        step();
        check("bp.empty", DW'(out_valid), 0);

        // Flush with both entries full and an incoming instruction
        out_ready = 1'b0;
        drive(1'b1, 64'h280, 5'd4, 1'b1); step();
        drive(1'b1, 64'h284, 5'd4, 1'b1); step();
        drive(1'b1, 64'h300, 5'd6, 1'b1);
        flush = 1'b1;
        check("flush.in_ready_full", DW'(in_ready), 0);
        step();
        flush = 1'b0;
        drive(1'b0, '0, '0, 1'b0);
        check("flush.out_valid", DW'(out_valid), 0);
        check("flush.in_ready", DW'(in_ready), 1);
        out_ready = 1'b1;
        step();
        check("flush.no_0x300", DW'(out_valid), 0);
        // Flush while ready: handshake completes, data dropped
        drive(1'b1, 64'h310, 5'd6, 1'b1);
        flush = 1'b1;
        check("flush.in_ready_empty", DW'(in_ready), 1);
        step();
        flush = 1'b0;
        drive(1'b0, '0, '0, 1'b0);
        check("flush.drop_accept", DW'(out_valid), 0);

        // rd == 0 masks the write enable
        drive(1'b1, 64'h500, 5'd0, 1'b1); step();
        check("rd0.out_rd_we", DW'(out_rd_we), 0);
        check("rd0.ex_rd_we", DW'(ex_rd_we), 0);
        drive(1'b1, 64'h504, 5'd5, 1'b1); step();
        check("rd5.out_rd_we", DW'(out_rd_we), 1);
        check("rd5.ex_rd", DW'(ex_rd), 5);
        check("rd5.ex_rd_we", DW'(ex_rd_we), 1);
        drive(1'b1, 64'h508, 5'd7, 1'b0); step();
        check("rd7nowe.out_rd_we", DW'(out_rd_we), 0);
        drive(1'b0, '0, '0, 1'b0); step();
        check("rd.ex_rd_we_invalid", DW'(ex_rd_we), 0);

        // Reset mid-operation
        out_ready = 1'b0;
        drive(1'b1, 64'h380, 5'd9, 1'b1); step();
        drive(1'b1, 64'h384, 5'd9, 1'b1); step();
        drive(1'b0, '0, '0, 1'b0);
        rst_n = 1'b0; flush = 1'b1; out_ready = 1'b1;
        step();
        rst_n = 1'b1; flush = 1'b0;
        check("mrst.out_valid", DW'(out_valid), 0);
        check("mrst.in_ready", DW'(in_ready), 1);
        check("mrst.out_pc", out_pc, 0);
        check("mrst.out_rs1_val", out_rs1_val, 0);
        check("mrst.out_op", DW'(out_op), 0);
        check("mrst.out_rd", DW'(out_rd), 0);
        drive(1'b1, 64'h400, 5'd8, 1'b1); step();
        drive(1'b0, '0, '0, 1'b0);
        check("mrst.out_valid2", DW'(out_valid), 1);
        check("mrst.pc400", out_pc, 64'h400);
        step();

        // Random valid/ready against an in-order scoreboard
        next_pc = 64'h1000;
        held = 1'b0;
        held_pc = '0;
        for (int c = 0; c < 400; c++) begin
            if (held) begin
                check("rand.hold_valid", DW'(out_valid), 1);
                check("rand.hold_pc", out_pc, held_pc);
            end
            drive(($urandom_range(0, 3) != 0), next_pc, next_pc[6:2], next_pc[2]);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 24) == 0);
            acc = in_valid && in_ready;
            con = out_valid && out_ready;
            if (flush) begin
                q.delete();
            end else begin
                if (con) begin
                    if (q.size() == 0) begin
                        check("rand.spurious", out_pc, '1);
                    end else begin
                        exp_pc = q.pop_front();
                        check_payload("rand", exp_pc);
                        check("rand.rd_we", DW'(out_rd_we),
                              DW'(exp_pc[2] && (exp_pc[6:2] != 5'd0)));
                    end
                end
                if (acc) q.push_back(next_pc);
            end
            if (acc) next_pc = next_pc + 4;
            held    = out_valid && !out_ready && !flush;
            held_pc = out_pc;
            step();
        end

        // Drain within a bounded number of cycles
        flush = 1'b0;
        drive(1'b0, '0, '0, 1'b0);
        out_ready = 1'b1;
        drain = 0;
        while (q.size() != 0 && drain < 10) begin
            if (out_valid) begin
                exp_pc = q.pop_front();
                check_payload("drain", exp_pc);
            end
            step();
            drain++;
        end
        check("drain.left", DW'(q.size()), 0);
        check("drain.out_valid", DW'(out_valid), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, operand/PC width.
REQ-002 SHALL have parameter REG_NUM, default 32, register count; RW = $clog2(REG_NUM).
REQ-003 SHALL have parameter OP_WIDTH, default 8, decoded-op width.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 flush  input  1  discard all held and incoming instructions this cycle.
REQ-007 in_valid  input  1  upstream (decode/bypass) holds an instruction.
REQ-008 in_ready  output  1  stage can accept this cycle.
REQ-009 in_rs1_val, in_rs2_val  input  DATA_WIDTH each  post-bypass operand values.
REQ-010 in_rs1, in_rs2, in_rd  input  RW each  source/destination register indices.
REQ-011 in_rd_we  input  1  instruction writes rd.
REQ-012 in_pc  input  DATA_WIDTH  instruction PC.
REQ-013 in_op  input  OP_WIDTH  decoded operation.
REQ-014 out_valid  output  1  execute-side instruction present.
REQ-015 out_ready  input  1  execute stage accepts this cycle.
REQ-016 out_rs1_val, out_rs2_val, out_rs1, out_rs2, out_rd, out_pc, out_op  output  widths as inputs  registered payload.
REQ-017 out_rd_we  output  1  registered write enable, forced 0 when out_rd == 0.
REQ-018 ex_rd, ex_rd_we  output  RW, 1  copy of out_rd / (out_rd_we & out_valid), fed back to bypass ex_pro_rs comparison.

Function
REQ-019 Storage SHALL be two payload entries: MAIN (drives outputs) and SKID, each with a valid bit.
REQ-020 in_ready SHALL equal !skid_valid (combinational from registers only, no path from out_ready).
REQ-021 Accept SHALL occur when in_valid & in_ready; consume SHALL occur when out_valid & out_ready.
REQ-022 out_valid SHALL equal main_valid; out payload SHALL come only from MAIN.
REQ-023 Accept, MAIN empty or being consumed, SKID empty: input -> MAIN next cycle; latency 1 cycle in to out.
REQ-024 Accept while MAIN valid and not consumed: input -> SKID, skid_valid=1.
REQ-025 Consume with SKID valid: SKID -> MAIN, skid_valid=0; no accept possible that cycle (in_ready=0).
REQ-026 Consume, SKID empty, no accept: main_valid=0.
REQ-027 Payload registers SHALL load only on the transfers above; held payload SHALL be stable while out_valid & !out_ready.
REQ-028 Stored rd write enable SHALL be in_rd_we & (in_rd != 0).
REQ-029 flush SHALL clear main_valid and skid_valid next cycle, overriding simultaneous accept and consume; an accept in a flush cycle is dropped.
REQ-030 in_ready SHALL remain !skid_valid during flush (handshake completes, data discarded).
REQ-031 Order SHALL be preserved: no instruction overtakes an earlier accepted one.
REQ-032 Throughput SHALL be one instruction per cycle when out_ready held 1.
REQ-033 Occupancy SHALL never exceed 2; no entry overwritten while valid.

Reset
REQ-034 On rst_n=0 at a rising edge: main_valid=0, skid_valid=0, all payload registers 0.
REQ-035 Outputs after reset: out_valid=0, in_ready=1, out_rd_we=0, ex_rd=0, ex_rd_we=0, other payload 0.
REQ-036 Reset SHALL override flush and all handshakes; reset mid-transfer discards both entries.

Verification
REQ-037 Stream: out_ready=1, in_valid=1 for 4 cycles, pc 0x100,0x104,0x108,0x10C -> out_valid from cycle 1, pcs out in order, one per cycle, in_ready always 1.
REQ-038 Backpressure: out_ready=0, send pc 0x200, 0x204 -> in_ready=0 after second accept, out_pc=0x200 held; raise out_ready -> 0x200 then 0x204, in_ready returns 1 after first consume.
REQ-039 Flush: both entries full, assert flush with in_valid=1 (pc 0x300) -> next cycle out_valid=0, in_ready=1, 0x300 never appears.
REQ-040 rd zero: accept in_rd=0, in_rd_we=1 -> out_rd_we=0, ex_rd_we=0; in_rd=5, in_rd_we=1 -> out_rd_we=1, ex_rd=5.
REQ-041 Reset mid-operation: both entries full, rst_n=0 one cycle -> out_valid=0, in_ready=1, all payload 0; subsequent pc 0x400 emerges after 1 cycle.
REQ-042 Random valid/ready with scoreboard: every accepted payload emerges exactly once, in order, unless flushed; no change on held payload.
